fetch_unit: RTL and testbench

//  Dual-wide instruction fetch stage upstream of the 1-cycle instruction ROM. Generates the PC pair (PC, PC+4),

---
 rtl/fetch_unit.sv | 150 +++++++++++++++
 tb/tb_fetch_unit.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Dual-wide fetch stage: PC pair generation, credit-gated ROM reads, fetch queue, redirect flush.
// Optional performance counters are built when FETCH_PERF_EN is defined.
module fetch_unit #(
  parameter int unsigned     XLEN     = 32,
  parameter int unsigned     FQ_DEPTH = 8,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic                 clk,
  input  logic                 reset_n,
  output logic                 imem_ren,
  output logic [XLEN-1:0]      imem_addr0,
  output logic [XLEN-1:0]      imem_addr1,
  input  logic                 imem_valid,
  input  logic [XLEN-1:0]      imem_rdata0,
  input  logic [XLEN-1:0]      imem_rdata1,
  input  logic [1:0][XLEN-1:0] imem_pc,
  input  logic                 redirect_valid,
  input  logic [XLEN-1:0]      redirect_pc,
  output logic [1:0]           dec_valid,
  output logic [1:0][XLEN-1:0] dec_instr,
  output logic [1:0][XLEN-1:0] dec_pc,
  input  logic                 dec_ready
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]          perf_fetched,
  output logic [31:0]          perf_stall,
  output logic [15:0]          perf_flush
`endif
);

  localparam int unsigned PW = $clog2(FQ_DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned SW = CW + 1;

  logic [XLEN-1:0] pc_q;
  logic [CW-1:0]   count_q;
  logic [PW-1:0]   rd_ptr_q;
  logic [PW-1:0]   wr_ptr_q;
  logic            inflight_q;
  logic            drop_q;

  logic [XLEN-1:0] fq_pc    [FQ_DEPTH];
  logic [XLEN-1:0] fq_instr [FQ_DEPTH];

  logic [SW-1:0]   credit_c;
  logic            credit_ok_c;
  logic            issue_c;
  logic            accept_c;
  logic [CW-1:0]   pop_c;
  logic [CW-1:0]   count_next_c;
  logic [PW-1:0]   rd_ptr_p1_c;
  logic [PW-1:0]   wr_ptr_p1_c;

  // Credit check, response qualification and decode-side presentation
  always_comb begin
    credit_c     = SW'(count_q) + (inflight_q ? SW'(2) : SW'(0)) + SW'(2);
    credit_ok_c  = (credit_c <= SW'(FQ_DEPTH));
    issue_c      = reset_n && !redirect_valid && credit_ok_c;
    // imem_valid is only meaningful in the cycle right after an issue
    accept_c     = inflight_q && imem_valid && !drop_q && !redirect_valid;
    rd_ptr_p1_c  = rd_ptr_q + PW'(1);
    wr_ptr_p1_c  = wr_ptr_q + PW'(1);
    dec_valid    = 2'b00;
    if (!redirect_valid) begin
      dec_valid = {count_q >= CW'(2), count_q >= CW'(1)};
    end
    pop_c        = '0;
    if (dec_ready) begin
      pop_c = CW'(dec_valid[0]) + CW'(dec_valid[1]);
    end
    count_next_c = count_q + (accept_c ? CW'(2) : CW'(0)) - pop_c;
    dec_pc[0]    = fq_pc[rd_ptr_q];
    dec_pc[1]    = fq_pc[rd_ptr_p1_c];
    dec_instr[0] = fq_instr[rd_ptr_q];
    dec_instr[1] = fq_instr[rd_ptr_p1_c];
  end

  assign imem_ren   = issue_c;
  assign imem_addr0 = pc_q;
  assign imem_addr1 = pc_q + XLEN'(4);

  // PC, queue pointers and request tracking
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc_q       <= RESET_PC;
      count_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      inflight_q <= 1'b0;
      drop_q     <= 1'b0;
    end else if (redirect_valid) begin
      pc_q       <= redirect_pc & ~XLEN'(3);
      count_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      inflight_q <= 1'b0;
      drop_q     <= inflight_q;
    end else begin
      if (issue_c) begin
        pc_q <= pc_q + XLEN'(8);
      end
      if (accept_c) begin
        wr_ptr_q <= wr_ptr_q + PW'(2);
      end
      rd_ptr_q   <= rd_ptr_q + PW'(pop_c);
      count_q    <= count_next_c;
      inflight_q <= issue_c;
      drop_q     <= 1'b0;
    end
  end

  // Queue storage carries no reset; dec_valid masks stale entries
  always_ff @(posedge clk) begin
    if (accept_c) begin
      fq_pc[wr_ptr_q]       <= imem_pc[0];
      fq_instr[wr_ptr_q]    <= imem_rdata0;
      fq_pc[wr_ptr_p1_c]    <= imem_pc[1];
      fq_instr[wr_ptr_p1_c] <= imem_rdata1;
    end
  end

`ifdef FETCH_PERF_EN
  // Saturating event counters
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      perf_fetched <= '0;
      perf_stall   <= '0;
      perf_flush   <= '0;
    end else begin
      if (accept_c) begin
        perf_fetched <= (perf_fetched > 32'hFFFF_FFFD) ? 32'hFFFF_FFFF : perf_fetched + 32'd2;
      end
      if (!redirect_valid && !credit_ok_c && (perf_stall != 32'hFFFF_FFFF)) begin
        perf_stall <= perf_stall + 32'd1;
      end
      if (redirect_valid && (perf_flush != 16'hFFFF)) begin
        perf_flush <= perf_flush + 16'd1;
      end
    end
  end
`endif

  a_resp_missing: assert property (@(posedge clk) disable iff (!reset_n)
    inflight_q |-> imem_valid);
  a_overflow: assert property (@(posedge clk) disable iff (!reset_n)
    !redirect_valid |-> (SW'(count_q) + (accept_c ? SW'(2) : SW'(0)) <= SW'(FQ_DEPTH) + SW'(pop_c)));
  a_underflow: assert property (@(posedge clk) disable iff (!reset_n)
    pop_c <= count_q);

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: streaming, back-pressure, redirect, PC wrap and mid-request reset.
module tb_fetch_unit;

  localparam int unsigned XLEN = 32;

  logic                 clk = 1'b0;
  logic                 reset_n;
  logic                 imem_ren;
  logic [XLEN-1:0]      imem_addr0;
  logic [XLEN-1:0]      imem_addr1;
  logic                 imem_valid;
  logic [XLEN-1:0]      imem_rdata0;
  logic [XLEN-1:0]      imem_rdata1;
  logic [1:0][XLEN-1:0] imem_pc;
  logic                 redirect_valid;
  logic [XLEN-1:0]      redirect_pc;
  logic [1:0]           dec_valid;
  logic [1:0][XLEN-1:0] dec_instr;
  logic [1:0][XLEN-1:0] dec_pc;
  logic                 dec_ready;
`ifdef FETCH_PERF_EN
  logic [31:0]          perf_fetched;
  logic [31:0]          perf_stall;
  logic [15:0]          perf_flush;
`endif

  logic rom_rv = 1'b0;
  logic rom_stuck;
  int   n_cmp = 0;
  int   n_bad = 0;

  fetch_unit dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .imem_ren       (imem_ren),
    .imem_addr0     (imem_addr0),
    .imem_addr1     (imem_addr1),
    .imem_valid     (imem_valid),
    .imem_rdata0    (imem_rdata0),
    .imem_rdata1    (imem_rdata1),
    .imem_pc        (imem_pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .dec_valid      (dec_valid),
    .dec_instr      (dec_instr),
    .dec_pc         (dec_pc),
    .dec_ready      (dec_ready)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetched   (perf_fetched),
    .perf_stall     (perf_stall),
    .perf_flush     (perf_flush)
`endif
  );

  always #5 clk = ~clk;

  // ROM contents: word at byte address a is 0x10 + a/4
  function automatic logic [31:0] rom_word(input logic [31:0] a);
    return 32'h10 + (a >> 2);
  endfunction

  // One-cycle ROM; valid can be forced high to model a ROM that holds it
  always @(posedge clk) begin
    rom_rv      <= imem_ren;
    imem_rdata0 <= rom_word(imem_addr0);
    imem_rdata1 <= rom_word(imem_addr1);
    imem_pc[0]  <= imem_addr0;
    imem_pc[1]  <= imem_addr1;
  end
  assign imem_valid = rom_rv | rom_stuck;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_dec(input string tag, input logic [1:0] dv,
                         input logic [31:0] p0, input logic [31:0] i0,
                         input logic [31:0] p1, input logic [31:0] i1);
    chk({tag, ".dec_valid"}, 32'(dec_valid), 32'(dv));
    if (dv[0]) begin
      chk({tag, ".pc0"}, dec_pc[0], p0);
      chk({tag, ".instr0"}, dec_instr[0], i0);
    end
    if (dv[1]) begin
      chk({tag, ".pc1"}, dec_pc[1], p1);
      chk({tag, ".instr1"}, dec_instr[1], i1);
    end
  endtask

  typedef struct {
    logic        rd;
    logic        rdy;
    logic        stuck;
    logic        ren;
    logic [31:0] a0;
    logic [1:0]  dv;
    logic [31:0] p0;
    logic [31:0] i0;
    logic [31:0] p1;
    logic [31:0] i1;
  } vec_t;

  function automatic vec_t mk(input logic rd, input logic rdy, input logic st, input logic ren,
                              input logic [31:0] a0, input logic [1:0] dv,
                              input logic [31:0] p0, input logic [31:0] i0,
                              input logic [31:0] p1, input logic [31:0] i1);
    vec_t v;
    v.rd = rd; v.rdy = rdy; v.stuck = st; v.ren = ren; v.a0 = a0; v.dv = dv;
    v.p0 = p0; v.i0 = i0; v.p1 = p1; v.i1 = i1;
    return v;
  endfunction

  vec_t vt [20];

  initial begin
    // Streaming, back-pressure with stuck ROM valid, drain, then redirect to 0x43
    vt[0]  = mk(1'b0, 1'b1, 1'b0, 1'b1, 32'h00, 2'b00, 32'h00, 32'h00, 32'h00, 32'h00);
    vt[1]  = mk(1'b0, 1'b1, 1'b0, 1'b1, 32'h08, 2'b00, 32'h00, 32'h00, 32'h00, 32'h00);
    vt[2]  = mk(1'b0, 1'b1, 1'b0, 1'b1, 32'h10, 2'b11, 32'h00, 32'h10, 32'h04, 32'h11);
    vt[3]  = mk(1'b0, 1'b1, 1'b0, 1'b1, 32'h18, 2'b11, 32'h08, 32'h12, 32'h0C, 32'h13);
    vt[4]  = mk(1'b0, 1'b1, 1'b0, 1'b1, 32'h20, 2'b11, 32'h10, 32'h14, 32'h14, 32'h15);
    vt[5]  = mk(1'b0, 1'b0, 1'b0, 1'b1, 32'h28, 2'b11, 32'h18, 32'h16, 32'h1C, 32'h17);
    vt[6]  = mk(1'b0, 1'b0, 1'b0, 1'b1, 32'h30, 2'b11, 32'h18, 32'h16, 32'h1C, 32'h17);
    vt[7]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 32'h38, 2'b11, 32'h18, 32'h16, 32'h1C, 32'h17);
    vt[8]  = mk(1'b0, 1'b0, 1'b1, 1'b0, 32'h38, 2'b11, 32'h18, 32'h16, 32'h1C, 32'h17);
    vt[9]  = mk(1'b0, 1'b0, 1'b1, 1'b0, 32'h38, 2'b11, 32'h18, 32'h16, 32'h1C, 32'h17);
    vt[10] = mk(1'b0, 1'b1, 1'b0, 1'b0, 32'h38, 2'b11, 32'h18, 32'h16, 32'h1C, 32'h17);
    vt[11] = mk(1'b0, 1'b1, 1'b0, 1'b1, 32'h38, 2'b11, 32'h20, 32'h18, 32'h24, 32'h19);
    vt[12] = mk(1'b0, 1'b1, 1'b0, 1'b1, 32'h40, 2'b11, 32'h28, 32'h1A, 32'h2C, 32'h1B);
    vt[13] = mk(1'b0, 1'b1, 1'b0, 1'b1, 32'h48, 2'b11, 32'h30, 32'h1C, 32'h34, 32'h1D);
    vt[14] = mk(1'b0, 1'b1, 1'b0, 1'b1, 32'h50, 2'b11, 32'h38, 32'h1E, 32'h3C, 32'h1F);
    vt[15] = mk(1'b1, 1'b1, 1'b0, 1'b0, 32'h58, 2'b00, 32'h00, 32'h00, 32'h00, 32'h00);
    vt[16] = mk(1'b0, 1'b1, 1'b0, 1'b1, 32'h40, 2'b00, 32'h00, 32'h00, 32'h00, 32'h00);
    vt[17] = mk(1'b0, 1'b1, 1'b0, 1'b1, 32'h48, 2'b00, 32'h00, 32'h00, 32'h00, 32'h00);
    vt[18] = mk(1'b0, 1'b1, 1'b0, 1'b1, 32'h50, 2'b11, 32'h40, 32'h20, 32'h44, 32'h21);
    vt[19] = mk(1'b0, 1'b1, 1'b0, 1'b1, 32'h58, 2'b11, 32'h48, 32'h22, 32'h4C, 32'h23);

    reset_n        = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    dec_ready      = 1'b1;
    rom_stuck      = 1'b0;
    #2;
    chk("rst.ren", 32'(imem_ren), 32'h0);
    chk("rst.addr0", imem_addr0, 32'h0);
    chk("rst.addr1", imem_addr1, 32'h4);
    chk("rst.dec_valid", 32'(dec_valid), 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < 20; i++) begin
      redirect_valid = vt[i].rd;
      redirect_pc    = vt[i].rd ? 32'h43 : 32'h0;
      dec_ready      = vt[i].rdy;
      rom_stuck      = vt[i].stuck;
      #1;
      chk($sformatf("v%0d.ren", i), 32'(imem_ren), 32'(vt[i].ren));
      chk($sformatf("v%0d.addr0", i), imem_addr0, vt[i].a0);
      chk($sformatf("v%0d.addr1", i), imem_addr1, vt[i].a0 + 32'd4);
      chk_dec($sformatf("v%0d", i), vt[i].dv, vt[i].p0, vt[i].i0, vt[i].p1, vt[i].i1);
      @(posedge clk);
      @(negedge clk);
    end

    // PC pair wraps around the top of the address space
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFF8;
    dec_ready      = 1'b1;
    #1;
    chk("wrap.redir_ren", 32'(imem_ren), 32'h0);
    @(posedge clk);
    @(negedge clk);
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    #1;
    chk("wrap.ren", 32'(imem_ren), 32'h1);
    chk("wrap.addr0", imem_addr0, 32'hFFFF_FFF8);
    chk("wrap.addr1", imem_addr1, 32'hFFFF_FFFC);
    @(posedge clk);
    @(negedge clk);
    #1;
    chk("wrap.next_addr0", imem_addr0, 32'h0);
    @(posedge clk);
    @(negedge clk);
    #1;
    chk_dec("wrap.dec", 2'b11, 32'hFFFF_FFF8, rom_word(32'hFFFF_FFF8),
            32'hFFFF_FFFC, rom_word(32'hFFFF_FFFC));

    // Reset while a request is in flight with four entries queued
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0;
    dec_ready      = 1'b0;
    @(posedge clk);
    @(negedge clk);
    redirect_valid = 1'b0;
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
    end
    #1;
    chk_dec("prerst", 2'b11, 32'h0, 32'h10, 32'h4, 32'h11);
    chk("prerst.ren", 32'(imem_ren), 32'h1);
    chk("prerst.addr0", imem_addr0, 32'h18);
    reset_n = 1'b0;
    #1;
    chk("midrst.ren", 32'(imem_ren), 32'h0);
    chk("midrst.dec_valid", 32'(dec_valid), 32'h0);
    chk("midrst.addr0", imem_addr0, 32'h0);
    chk("midrst.addr1", imem_addr1, 32'h4);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    chk("postrst.ren", 32'(imem_ren), 32'h1);
    chk("postrst.addr0", imem_addr0, 32'h0);
    chk("postrst.dec_valid", 32'(dec_valid), 32'h0);
    repeat (2) begin
      @(posedge clk);
      @(negedge clk);
    end
    #1;
    chk_dec("postrst.dec", 2'b11, 32'h0, 32'h10, 32'h4, 32'h11);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
